// File: rtl/knight_rider_pkg.sv
// Shared types and helpers for the Knight Rider LED scanner.
// Holds the bounce FSM encoding, LED count default and the position-to-LED decoder.
package knight_rider_pkg;

    localparam int unsigned NLED_DEFAULT = 10;
    localparam int unsigned POS_W        = 4;
    localparam int unsigned MAX_LEDS     = 1 << POS_W;

    typedef enum logic [1:0] {
        StStop = 2'd0,
        StUp   = 2'd1,
        StDown = 2'd2
    } scan_state_e;

    // Widest possible word; callers keep the low NLED bits.
    function automatic logic [MAX_LEDS-1:0] pos_onehot(input logic [POS_W-1:0] pos);
        logic [MAX_LEDS-1:0] oh;
        oh      = '0;
        oh[pos] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low push button.
// Emits a one-cycle press pulse on the cycle the debounced level falls.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    logic w_mismatch;
    logic w_accept;

    assign w_mismatch = (r_sync2 != r_level);
    assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);
    assign o_press    = w_accept && !r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/knight_rider_scanner.sv
// Bouncing LED scanner with a trailing tail, started and stopped by a debounced key.
// All outputs come straight from flops; the FSM only acts on the registered run flag.
module knight_rider_scanner
    import knight_rider_pkg::*;
#(
    parameter int unsigned NLED       = NLED_DEFAULT,
    parameter int unsigned TAIL_LEN   = 2,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            KEY_N,
    input  logic            TICK,
    output logic [NLED-1:0] LEDR,
    output logic [3:0]      POS,
    output logic            DIR,
    output logic            RUN
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NLED - 1);
    localparam logic [NLED-1:0]  LED0     = {{(NLED-1){1'b0}}, 1'b1};

    logic w_press;

    logic              r_run;
    scan_state_e       r_state;
    logic [POS_W-1:0]  r_pos;
    logic              r_dir;
    logic [NLED-1:0]   r_ledr;
    logic [NLED-1:0]   r_hist [TAIL_LEN+1];

    scan_state_e       w_step_state;
    logic [POS_W-1:0]  w_step_pos;
    logic [MAX_LEDS-1:0] w_oh_full;
    logic [NLED-1:0]   w_step_oh;
    logic [NLED-1:0]   w_keep_or;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_key_n (KEY_N),
        .o_press (w_press)
    );

    // Head position and state after one tick; the ends turn around without dwelling.
    always_comb begin
        w_step_state = r_state;
        w_step_pos   = r_pos;
        case (r_state)
            StUp: begin
                if (r_pos < LAST_POS) begin
                    w_step_pos = r_pos + 1'b1;
                end else begin
                    w_step_pos   = LAST_POS - 1'b1;
                    w_step_state = StDown;
                end
            end
            StDown: begin
                if (r_pos != '0) begin
                    w_step_pos = r_pos - 1'b1;
                end else begin
                    w_step_pos   = POS_W'(1);
                    w_step_state = StUp;
                end
            end
            default: begin
                w_step_state = r_state;
                w_step_pos   = r_pos;
            end
        endcase
    end

    assign w_oh_full = pos_onehot(w_step_pos);
    assign w_step_oh = w_oh_full[NLED-1:0];

    if (NLED < MAX_LEDS) begin : g_oh_unused
        logic w_unused_oh;
        assign w_unused_oh = ^w_oh_full[MAX_LEDS-1:NLED];
    end

    // Entries that survive the shift, i.e. everything but the oldest.
    always_comb begin
        w_keep_or = '0;
        for (int i = 0; i < int'(TAIL_LEN); i++) begin
            w_keep_or = w_keep_or | r_hist[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_run   <= 1'b0;
            r_state <= StStop;
            r_pos   <= '0;
            r_dir   <= 1'b1;
            r_ledr  <= '0;
            for (int i = 0; i <= int'(TAIL_LEN); i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            if (w_press) begin
                r_run <= !r_run;
            end

            if (!r_run) begin
                if (r_state != StStop) begin
                    r_state <= StStop;
                    r_pos   <= '0;
                    r_dir   <= 1'b1;
                    r_ledr  <= '0;
                    for (int i = 0; i <= int'(TAIL_LEN); i++) begin
                        r_hist[i] <= '0;
                    end
                end
            end else if (r_state == StStop) begin
                r_state <= StUp;
                r_pos   <= '0;
                r_dir   <= 1'b1;
                r_ledr  <= LED0;
                r_hist[0] <= LED0;
                for (int i = 1; i <= int'(TAIL_LEN); i++) begin
                    r_hist[i] <= '0;
                end
            end else if (TICK && !w_press) begin
                // A tick landing on a run toggle is dropped so stop wins cleanly.
                r_state   <= w_step_state;
                r_pos     <= w_step_pos;
                r_dir     <= (w_step_state == StUp);
                r_ledr    <= w_step_oh | w_keep_or;
                r_hist[0] <= w_step_oh;
                for (int i = 1; i <= int'(TAIL_LEN); i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
            end
        end
    end

    assign LEDR = r_ledr;
    assign POS  = r_pos;
    assign DIR  = r_dir;
    assign RUN  = r_run;

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Scoreboard bench: stimulus pushes model predictions per clock, a monitor pops and compares.
// The model derives head/tail from a step count and the bounce period, not from FSM state.
module tb_knight_rider_scanner;

    localparam int NLED     = 10;
    localparam int TAIL     = 2;
    localparam int DEB      = 4;
    localparam int TICK_PER = 8;
    localparam int PERIOD   = 2 * (NLED - 1);

    logic            CLK   = 1'b0;
    logic            RST_N = 1'b0;
    logic            KEY_N = 1'b1;
    logic            TICK  = 1'b0;
    logic [NLED-1:0] LEDR;
    logic [3:0]      POS;
    logic            DIR;
    logic            RUN;

    knight_rider_scanner #(
        .NLED       (NLED),
        .TAIL_LEN   (TAIL),
        .DEB_CYCLES (DEB)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .KEY_N (KEY_N),
        .TICK  (TICK),
        .LEDR  (LEDR),
        .POS   (POS),
        .DIR   (DIR),
        .RUN   (RUN)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NLED-1:0] ledr;
        logic [3:0]      pos;
        logic            dir;
        logic            run;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model state
    bit m_s1, m_s2, m_deb, m_run, m_active;
    int m_mis, m_k;

    function automatic int head_at(int k);
        int p = k % PERIOD;
        return (p < NLED) ? p : PERIOD - p;
    endfunction

    function automatic bit dir_at(int k);
        int p = k % PERIOD;
        return (k == 0) || (p >= 1 && p <= NLED - 1);
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.run = m_run;
        if (m_active) begin
            o.pos  = 4'(head_at(m_k));
            o.dir  = dir_at(m_k);
            o.ledr = '0;
            for (int j = m_k - TAIL; j <= m_k; j++) begin
                if (j >= 0) o.ledr[head_at(j)] = 1'b1;
            end
        end else begin
            o.pos  = 4'd0;
            o.dir  = 1'b1;
            o.ledr = '0;
        end
        return o;
    endfunction

    function automatic void model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1;
        m_mis = 0; m_run = 1'b0; m_active = 1'b0; m_k = 0;
    endfunction

    function automatic void model_edge(bit key, bit tick);
        bit press = 1'b0;
        // Level is accepted after DEB consecutive synchronised samples disagree with it.
        if (m_s2 != m_deb) begin
            m_mis++;
            if (m_mis == DEB) begin
                m_deb = m_s2;
                m_mis = 0;
                press = !m_s2;
            end
        end else begin
            m_mis = 0;
        end
        m_s2 = m_s1;
        m_s1 = key;
        if (m_run && !m_active) begin
            m_active = 1'b1;
            m_k      = 0;
        end else if (!m_run && m_active) begin
            m_active = 1'b0;
        end else if (m_active && tick && !press) begin
            m_k++;
        end
        if (press) m_run = !m_run;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    task automatic step(input bit key);
        KEY_N = key;
        TICK  = (cyc % TICK_PER == TICK_PER - 1);
        @(posedge CLK);
        if (!RST_N) model_reset();
        else model_edge(key, TICK);
        exp_q.push_back(model_out());
        cyc++;
        @(negedge CLK);
    endtask

    // Monitor: one prediction per clock edge
    always begin
        @(posedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            obs_t e;
            obs_t g;
            e = exp_q.pop_front();
            g = {LEDR, POS, DIR, RUN};
            n_checks++;
            if (g === e) n_pass++;
            else $display("FAIL scoreboard cyc=%0d: got LEDR=%h POS=%0d DIR=%b RUN=%b, expected LEDR=%h POS=%0d DIR=%b RUN=%b",
                          cyc, g.ledr, g.pos, g.dir, g.run, e.ledr, e.pos, e.dir, e.run);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int nchat;
        model_reset();

        // Reset then idle with ticks running
        RST_N = 1'b0;
        repeat (3) step(1'b1);
        RST_N = 1'b1;
        repeat (20) step(1'b1);

        // Clean press, then a full bounce period and more
        repeat (10) step(1'b0);
        repeat (200) step(1'b1);

        // Chattering key followed by a solid press: one toggle (stop)
        for (int i = 0; i < 3; i++) begin
            step(1'b0); step(1'b0); step(1'b1); step(1'b1);
        end
        repeat (10) step(1'b0);
        repeat (40) step(1'b1);

        // Random chatter/press/idle sequences
        for (int it = 0; it < 8; it++) begin
            nchat = $urandom_range(0, 5);
            for (int c = 0; c < nchat; c++) begin
                repeat ($urandom_range(1, 3)) step(1'b0);
                repeat ($urandom_range(1, 3)) step(1'b1);
            end
            repeat ($urandom_range(6, 12)) step(1'b0);
            repeat ($urandom_range(10, 160)) step(1'b1);
        end

        // Make sure the scanner runs
        if (!m_run) begin
            repeat (8) step(1'b0);
            repeat (12) step(1'b1);
        end

        // Stop accepted on the same edge as a tick at head 5
        guard = 0;
        while (!(m_active && head_at(m_k) == 5 && cyc % TICK_PER == 0) && guard < 400) begin
            step(1'b1);
            guard++;
        end
        check_val("reach_pos5", 32'(guard < 400), 32'd1);
        step(1'b1);
        step(1'b1);
        repeat (10) step(1'b0);
        repeat (30) step(1'b1);

        // Restart from LED0
        repeat (8) step(1'b0);
        repeat (60) step(1'b1);

        // Asynchronous reset mid-scan at head 6 moving down
        guard = 0;
        while (!(m_active && head_at(m_k) == 6 && !dir_at(m_k)) && guard < 400) begin
            step(1'b1);
            guard++;
        end
        check_val("reach_pos6_down", 32'(guard < 400), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check_val("async_ledr", 32'(LEDR), 32'd0);
        check_val("async_pos", 32'(POS), 32'd0);
        check_val("async_dir", 32'(DIR), 32'd1);
        check_val("async_run", 32'(RUN), 32'd0);
        model_reset();
        repeat (3) step(1'b1);
        RST_N = 1'b1;
        repeat (30) step(1'b1);

        repeat (2) @(negedge CLK);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
